// File: rtl/iob_bus_arbiter.sv
// N-to-1 IOb native arbiter: round-robin grant, locked while a request waits
// for ready, with an in-order owner FIFO that routes read responses back.
module iob_bus_arbiter #(
  parameter int ADDR_W   = 32,
  parameter int DATA_W   = 32,
  parameter int N        = 2,
  parameter int NB       = $clog2(N),
  parameter int RD_DEPTH = 4
) (
  input  logic                       clk_i,
  input  logic                       cke_i,
  input  logic                       rst_i,
  input  logic [N-1:0]               m_valid_i,
  input  logic [N*ADDR_W-1:0]        m_addr_i,
  input  logic [N*DATA_W-1:0]        m_wdata_i,
  input  logic [N*(DATA_W/8)-1:0]    m_wstrb_i,
  output logic [N*DATA_W-1:0]        m_rdata_o,
  output logic [N-1:0]               m_rvalid_o,
  output logic [N-1:0]               m_ready_o,
  output logic                       f_valid_o,
  output logic [ADDR_W-1:0]          f_addr_o,
  output logic [DATA_W-1:0]          f_wdata_o,
  output logic [DATA_W/8-1:0]        f_wstrb_o,
  input  logic [DATA_W-1:0]          f_rdata_i,
  input  logic                       f_rvalid_i,
  input  logic                       f_ready_i,
  output logic [NB-1:0]              grant_o,
  output logic                       err_o
);

  localparam int STRB_W = DATA_W / 8;
  localparam int AW     = $clog2(RD_DEPTH);
  localparam int CW     = AW + 1;

  logic [NB-1:0] r_ptr;
  logic          r_lock;
  logic [NB-1:0] r_grant;
  logic          r_err;

  logic [NB-1:0] r_mem [RD_DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [CW-1:0] r_count;

  logic [NB-1:0] w_grant;
  logic          w_found;
  int            w_idx;
  logic          w_is_read;
  logic          w_block;
  logic          w_accept;
  logic          w_push;
  logic          w_pop;
  logic [NB-1:0] w_head;

  // Rotating priority search starting at r_ptr; falls back to the held grant.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
    w_grant = r_grant;
    w_found = 1'b0;
    w_idx   = 0;
    if (!r_lock) begin
      for (int i = 0; i < N; i++) begin
        w_idx = int'(r_ptr) + i;
        if (w_idx >= N) w_idx = w_idx - N;
        if (!w_found && m_valid_i[w_idx]) begin
          w_grant = NB'(w_idx);
          w_found = 1'b1;
        end
      end
    end
  end

  assign f_addr_o  = m_addr_i[int'(w_grant)*ADDR_W +: ADDR_W];
  assign f_wdata_o = m_wdata_i[int'(w_grant)*DATA_W +: DATA_W];
  assign f_wstrb_o = m_wstrb_i[int'(w_grant)*STRB_W +: STRB_W];

  // A read is held off while the owner FIFO has no room for its tag.
  assign w_is_read = (f_wstrb_o == '0);
  assign w_block   = w_is_read && (r_count == CW'(RD_DEPTH));
  assign f_valid_o = m_valid_i[w_grant] && !w_block;
  assign w_accept  = f_valid_o && f_ready_i;
  assign w_push    = w_accept && w_is_read;
  assign w_pop     = f_rvalid_i && (r_count != '0);
  assign w_head    = r_mem[r_rd_ptr];

  always_comb begin
    m_ready_o          = '0;
    m_ready_o[w_grant] = f_ready_i && !w_block;
  end

  always_comb begin
    m_rvalid_o = '0;
    if (w_pop) m_rvalid_o[w_head] = 1'b1;
  end

  assign m_rdata_o = {N{f_rdata_i}};
  assign grant_o   = w_grant;
  assign err_o     = r_err;

  // NOTE: sequential state uses non-blocking assignments so all registers sample the same pre-edge values.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_ptr    <= '0;
      r_lock   <= 1'b0;
      r_grant  <= '0;
      r_err    <= 1'b0;
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (cke_i) begin
      if (w_accept) begin
        r_lock <= 1'b0;
        r_ptr  <= (w_grant == NB'(N - 1)) ? '0 : w_grant + NB'(1);
      end else if (m_valid_i[w_grant]) begin
        r_lock  <= 1'b1;
        r_grant <= w_grant;
      end
      if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
      if (f_rvalid_i && (r_count == '0)) r_err <= 1'b1;
    end
  end

  // NOTE: the tag storage is not reset; r_count alone decides which entries are meaningful.
  always_ff @(posedge clk_i) begin
    if (cke_i && w_push) r_mem[r_wr_ptr] <= w_grant;
  end

endmodule

// File: tb/tb_iob_bus_arbiter.sv
// Directed bench for iob_bus_arbiter with N=2, RD_DEPTH=4: reset, single read,
// round-robin, grant lock, FIFO-full blocking, writes while full, error flag.
module tb_iob_bus_arbiter;

  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;
  localparam int N      = 2;
  localparam int NB     = 1;
  localparam int RD_D   = 4;

  logic              clk_i = 1'b0;
  logic              cke_i;
  logic              rst_i;
  logic [N-1:0]      m_valid_i;
  logic [N*ADDR_W-1:0] m_addr_i;
  logic [N*DATA_W-1:0] m_wdata_i;
  logic [N*4-1:0]    m_wstrb_i;
  logic [N*DATA_W-1:0] m_rdata_o;
  logic [N-1:0]      m_rvalid_o;
  logic [N-1:0]      m_ready_o;
  logic              f_valid_o;
  logic [ADDR_W-1:0] f_addr_o;
  logic [DATA_W-1:0] f_wdata_o;
  logic [3:0]        f_wstrb_o;
  logic [DATA_W-1:0] f_rdata_i;
  logic              f_rvalid_i;
  logic              f_ready_i;
  logic [NB-1:0]     grant_o;
  logic              err_o;

  int checks = 0;
  int errors = 0;

  iob_bus_arbiter #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .N(N), .NB(NB), .RD_DEPTH(RD_D)
  ) dut (
    .clk_i(clk_i), .cke_i(cke_i), .rst_i(rst_i),
    .m_valid_i(m_valid_i), .m_addr_i(m_addr_i), .m_wdata_i(m_wdata_i),
    .m_wstrb_i(m_wstrb_i), .m_rdata_o(m_rdata_o), .m_rvalid_o(m_rvalid_o),
    .m_ready_o(m_ready_o), .f_valid_o(f_valid_o), .f_addr_o(f_addr_o),
    .f_wdata_o(f_wdata_o), .f_wstrb_o(f_wstrb_o), .f_rdata_i(f_rdata_i),
    .f_rvalid_i(f_rvalid_i), .f_ready_i(f_ready_i), .grant_o(grant_o),
    .err_o(err_o)
  );

  always #5 clk_i = ~clk_i;

  // Inputs change on the falling edge; outputs are sampled 1 ns later.
  task automatic idle_inputs();
    m_valid_i  = '0;
    m_addr_i   = '0;
    m_wdata_i  = '0;
    m_wstrb_i  = '0;
    f_rdata_i  = '0;
    f_rvalid_i = 1'b0;
    f_ready_i  = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk_i);
    idle_inputs();
    cke_i = 1'b1;
    rst_i = 1'b1;
    @(negedge clk_i);
    rst_i = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    #1;
    checks++; if (f_valid_o !== 1'b0)  begin errors++; $display("FAIL reset_f_valid got %b exp 0", f_valid_o); end
    checks++; if (m_ready_o !== 2'b00) begin errors++; $display("FAIL reset_m_ready got %b exp 00", m_ready_o); end
    checks++; if (m_rvalid_o !== 2'b00) begin errors++; $display("FAIL reset_m_rvalid got %b exp 00", m_rvalid_o); end
    checks++; if (grant_o !== 1'b0)    begin errors++; $display("FAIL reset_grant got %0d exp 0", grant_o); end
    checks++; if (err_o !== 1'b0)      begin errors++; $display("FAIL reset_err got %b exp 0", err_o); end
  endtask

  task automatic test_single_read();
    do_reset();
    m_valid_i = 2'b01;
    m_addr_i[31:0] = 32'h10;
    f_ready_i = 1'b1;
    #1;
    checks++; if (f_valid_o !== 1'b1)    begin errors++; $display("FAIL rd_f_valid got %b exp 1", f_valid_o); end
    checks++; if (f_addr_o !== 32'h10)   begin errors++; $display("FAIL rd_f_addr got %h exp 10", f_addr_o); end
    checks++; if (m_ready_o !== 2'b01)   begin errors++; $display("FAIL rd_m_ready got %b exp 01", m_ready_o); end
    @(negedge clk_i);
    m_valid_i  = '0;
    f_ready_i  = 1'b0;
    f_rvalid_i = 1'b1;
    f_rdata_i  = 32'hCAFE;
    #1;
    checks++; if (m_rvalid_o !== 2'b01)  begin errors++; $display("FAIL rd_m_rvalid got %b exp 01", m_rvalid_o); end
    checks++; if (m_rdata_o[31:0] !== 32'hCAFE)  begin errors++; $display("FAIL rd_rdata0 got %h exp cafe", m_rdata_o[31:0]); end
    checks++; if (m_rdata_o[63:32] !== 32'hCAFE) begin errors++; $display("FAIL rd_rdata1 got %h exp cafe", m_rdata_o[63:32]); end
    @(negedge clk_i);
    f_rvalid_i = 1'b0;
    #1;
    checks++; if (err_o !== 1'b0) begin errors++; $display("FAIL rd_no_err got %b exp 0", err_o); end
  endtask

  task automatic test_round_robin();
    logic [1:0]  exp_rdy;
    logic [31:0] exp_addr;
    do_reset();
    m_valid_i = 2'b11;
    m_addr_i  = {32'h200, 32'h100};
    m_wstrb_i = 8'hFF;
    f_ready_i = 1'b1;
    for (int i = 0; i < 4; i++) begin
      exp_rdy  = (i % 2 == 1) ? 2'b10 : 2'b01;
      exp_addr = (i % 2 == 1) ? 32'h200 : 32'h100;
      #1;
      checks++; if (grant_o !== NB'(i % 2)) begin errors++; $display("FAIL rr_grant[%0d] got %0d exp %0d", i, grant_o, i % 2); end
      checks++; if (m_ready_o !== exp_rdy)  begin errors++; $display("FAIL rr_ready[%0d] got %b exp %b", i, m_ready_o, exp_rdy); end
      checks++; if (f_addr_o !== exp_addr)  begin errors++; $display("FAIL rr_addr[%0d] got %h exp %h", i, f_addr_o, exp_addr); end
      @(negedge clk_i);
    end
  endtask

  task automatic test_lock();
    do_reset();
    m_valid_i = 2'b10;
    m_addr_i  = {32'h300, 32'h400};
    m_wstrb_i = 8'hFF;
    f_ready_i = 1'b0;
    for (int c = 1; c <= 4; c++) begin
      if (c == 2) m_valid_i = 2'b11;
      if (c == 4) f_ready_i = 1'b1;
      #1;
      checks++; if (grant_o !== 1'b1) begin errors++; $display("FAIL lock_grant[c%0d] got %0d exp 1", c, grant_o); end
      checks++; if (m_ready_o !== ((c == 4) ? 2'b10 : 2'b00)) begin errors++; $display("FAIL lock_ready[c%0d] got %b", c, m_ready_o); end
      @(negedge clk_i);
    end
    m_valid_i = 2'b01;
    #1;
    checks++; if (grant_o !== 1'b0)    begin errors++; $display("FAIL lock_next_grant got %0d exp 0", grant_o); end
    checks++; if (m_ready_o !== 2'b01) begin errors++; $display("FAIL lock_next_ready got %b exp 01", m_ready_o); end
  endtask

  // Leaves the FIFO holding tags 1,0,1,0 (head first).
  task automatic test_fifo_full();
    do_reset();
    m_addr_i  = {32'h80, 32'h40};
    f_ready_i = 1'b1;
    for (int i = 0; i < 4; i++) begin
      m_valid_i = (i % 2 == 1) ? 2'b10 : 2'b01;
      #1;
      checks++; if (f_valid_o !== 1'b1) begin errors++; $display("FAIL full_accept_valid[%0d] got %b exp 1", i, f_valid_o); end
      checks++; if (m_ready_o !== m_valid_i) begin errors++; $display("FAIL full_accept_ready[%0d] got %b exp %b", i, m_ready_o, m_valid_i); end
      @(negedge clk_i);
    end
    m_valid_i = 2'b01;
    #1;
    checks++; if (f_valid_o !== 1'b0)  begin errors++; $display("FAIL full_block_valid got %b exp 0", f_valid_o); end
    checks++; if (m_ready_o !== 2'b00) begin errors++; $display("FAIL full_block_ready got %b exp 00", m_ready_o); end
    @(negedge clk_i);
    f_rvalid_i = 1'b1;
    f_rdata_i  = 32'h1111;
    #1;
    checks++; if (m_rvalid_o !== 2'b01) begin errors++; $display("FAIL full_pop_rvalid got %b exp 01", m_rvalid_o); end
    checks++; if (f_valid_o !== 1'b0)   begin errors++; $display("FAIL full_pop_same_cycle got %b exp 0", f_valid_o); end
    @(negedge clk_i);
    f_rvalid_i = 1'b0;
    #1;
    checks++; if (f_valid_o !== 1'b1)  begin errors++; $display("FAIL full_fifth_valid got %b exp 1", f_valid_o); end
    checks++; if (m_ready_o !== 2'b01) begin errors++; $display("FAIL full_fifth_ready got %b exp 01", m_ready_o); end
    @(negedge clk_i);
  endtask

  task automatic test_write_when_full();
    logic [1:0] exp_heads [4] = '{2'b10, 2'b01, 2'b10, 2'b01};
    m_valid_i = 2'b01;
    m_wstrb_i = 8'h0F;
    m_wdata_i = {32'h0, 32'hDEADBEEF};
    f_ready_i = 1'b1;
    #1;
    checks++; if (f_valid_o !== 1'b1)    begin errors++; $display("FAIL wr_full_valid got %b exp 1", f_valid_o); end
    checks++; if (m_ready_o !== 2'b01)   begin errors++; $display("FAIL wr_full_ready got %b exp 01", m_ready_o); end
    checks++; if (f_wdata_o !== 32'hDEADBEEF) begin errors++; $display("FAIL wr_full_wdata got %h exp deadbeef", f_wdata_o); end
    @(negedge clk_i);
    m_valid_i = 2'b10;
    m_wstrb_i = '0;
    #1;
    checks++; if (f_valid_o !== 1'b0) begin errors++; $display("FAIL wr_count_kept got f_valid %b exp 0", f_valid_o); end
    @(negedge clk_i);
    m_valid_i = '0;
    for (int i = 0; i < 4; i++) begin
      f_rvalid_i = 1'b1;
      #1;
      checks++; if (m_rvalid_o !== exp_heads[i]) begin errors++; $display("FAIL drain_rvalid[%0d] got %b exp %b", i, m_rvalid_o, exp_heads[i]); end
      @(negedge clk_i);
    end
    f_rvalid_i = 1'b0;
    #1;
    checks++; if (err_o !== 1'b0) begin errors++; $display("FAIL drain_err got %b exp 0", err_o); end
  endtask

  task automatic test_error();
    do_reset();
    cke_i      = 1'b0;
    f_rvalid_i = 1'b1;
    @(negedge clk_i);
    cke_i = 1'b1;
    #1;
    checks++; if (err_o !== 1'b0)       begin errors++; $display("FAIL err_cke_hold got %b exp 0", err_o); end
    checks++; if (m_rvalid_o !== 2'b00) begin errors++; $display("FAIL err_no_rvalid got %b exp 00", m_rvalid_o); end
    @(negedge clk_i);
    f_rvalid_i = 1'b0;
    #1;
    checks++; if (err_o !== 1'b1) begin errors++; $display("FAIL err_set got %b exp 1", err_o); end
    @(negedge clk_i);
    #1;
    checks++; if (err_o !== 1'b1) begin errors++; $display("FAIL err_sticky got %b exp 1", err_o); end
    do_reset();
    #1;
    checks++; if (err_o !== 1'b0) begin errors++; $display("FAIL err_cleared got %b exp 0", err_o); end
  endtask

  initial begin
    idle_inputs();
    cke_i = 1'b1;
    rst_i = 1'b1;
    test_reset();
    test_single_read();
    test_round_robin();
    test_lock();
    test_fifo_full();
    test_write_when_full();
    test_error();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
